devil_snoop_injector: RTL and testbench
=======================================

Name: devil_snoop_injector

Overview:
- Parametrised successor of the devil-in-the-FPGA snoop responder.
- Answers ACE snoops on the CR/CD channels in place of the normal snoop FSM, inserting programmable stall cycles before CRVALID, the first CDVALID, the last CD beat, or every CD beat.
- Supports one-shot, continuous and N-shot arming, ready-based back-pressure, configurable line/data width, and a served-snoop counter.

Parameters:
- C_ACE_DATA_WIDTH, 128: CD data bus width in bits.
- LINE_BYTES, 64: cache line size. BEATS = LINE_BYTES*8/C_ACE_DATA_WIDTH must be an integer ≥1.
- DELAY_W, 32: width of the delay counter.
- CNT_W, 16: width of the shot quota and served counter.

Ports:
- ace_aclk  in  1  clock.
- ace_aresetn  in  1  asynchronous active-low reset.
- i_trigger  in  1  level: snoop pending and handed to this block.
- i_enable  in  1  arm; the rising edge re-arms the quota.
- i_mode  in  2  0 one-shot, 1 continuous, 2 N-shot, 3 reserved (treated as disabled).
- i_target  in  2  0 CR, 1 first CD beat, 2 last CD beat, 3 every CD beat.
- i_delay  in  DELAY_W  stall cycles inserted at the target.
- i_shot_count  in  CNT_W  N-shot quota.
- i_crresp  in  5  response to drive; bit0 = DataTransfer.
- i_line_data  in  LINE_BYTES*8  line returned on CD; beat 0 is the LSBs.
- i_crready / i_cdready  in  1  channel ready.
- o_crvalid  out  1;  o_crresp  out  5.
- o_cdvalid  out  1;  o_cddata  out  C_ACE_DATA_WIDTH;  o_cdlast  out  1.
- o_busy  out  1  transaction in progress.
- o_done  out  1  one-cycle pulse per completed snoop.
- o_fsm_state  out  4  current state encoding.
- o_served_count  out  CNT_W  snoops served since the last re-arm.

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; latched config, beat index, delay counter, quota and served count cleared.
- State encodings: IDLE=0, CR_DLY=1, CR=2, CD_DLY=3, CD=4, END=5.
- Arming: a rising edge of i_enable (registered) clears o_served_count and sets the remaining quota.
  - Mode 0: quota = 1.
  - Mode 2: quota = i_shot_count.
  - Mode 1: unlimited.
- IDLE: accepts when i_enable && i_trigger && (mode==1 || quota>0) && mode!=3.
  - On accept: latch i_mode, i_target, i_delay, i_crresp, i_line_data; o_busy=1 from the next cycle.
  - Next state is CR_DLY if target==0 and delay>0, else CR.
- Delay semantics: delay D gives exactly D cycles with the valid low in *_DLY before the valid rises. D=0 skips the *_DLY state entirely.
- CR: o_crvalid=1 and o_crresp=latched value, held stable until i_crready.
  - On handshake, if crresp[0]=0, go to END.
  - Otherwise go to CD_DLY if (target==1 || target==3) and D>0, else CD.
- CD: o_cdvalid=1; o_cddata = beat[idx]; o_cdlast = (idx==BEATS-1). Held stable until i_cdready.
  - On handshake at the last beat, go to END.
  - Otherwise idx++, then:
    - target==3 and D>0: go to CD_DLY.
    - target==2, D>0 and the new idx==BEATS-1: go to CD_DLY.
    - Otherwise stay in CD (back-to-back beats).
  - BEATS==1: target 1 and target 2 both delay the single beat.
- CD_DLY: returns to CD with the same idx after D cycles.
- END: single cycle.
  - o_done=1.
  - o_served_count increments, saturating at 2^CNT_W-1.
  - Quota decrements (modes 0 and 2).
  - Next state IDLE; o_busy=0.
- Exhausted quota: triggers are ignored (o_busy stays 0) until i_enable falls and rises again.
- i_enable falling mid-transaction: the transaction completes normally and protocol is never violated; further accepts are blocked.
- Config changes mid-transaction have no effect (latched values are used).
- Delay counter: loads D on entry to *_DLY, decrements to 1, then exits. Full DELAY_W range is supported, with no wrap.
- Valid is never deasserted before its ready handshake. CR and CD are never valid in the same cycle.

Test Plan:
- One-shot, target=2, D=1, crresp=5'b00001, BEATS=4, ready tied high → CRVALID 1 cycle; beats 0–2 back-to-back; 1 idle cycle; beat 3 with CDLAST; o_done pulses; count=1; a second trigger is ignored.
- Continuous, target=0, D=2, 5 triggers, crresp=0 → each snoop shows 2 cycles in CR_DLY then CRVALID, no CDVALID; 5 o_done pulses; count=5.
- N-shot, N=3, target=1, D=4 → 3 snoops served with 4 stall cycles before beat 0; 4th trigger ignored; toggling i_enable re-arms and count returns to 0.
- Target=3, D=3, i_cdready low for 2 cycles on beat 1 → beat 1 data/valid stable for 3 cycles; 3 stall cycles between each beat; o_cddata matches the i_line_data slices.
- Reset asserted in CD at idx=2 → all outputs 0 immediately; after release, state IDLE and count=0.
- i_enable dropped in CR_DLY → the snoop still completes all 4 beats; no further accepts.

Source files
------------

// File: rtl/devil_snoop_injector.sv
// ACE snoop responder that answers CR/CD snoops and inserts programmable stall
// cycles before CRVALID, the first CD beat, the last CD beat or every CD beat.
module devil_snoop_injector #(
  parameter int unsigned C_ACE_DATA_WIDTH = 128,
  parameter int unsigned LINE_BYTES       = 64,
  parameter int unsigned DELAY_W          = 32,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                        ace_aclk,
  input  logic                        ace_aresetn,
  input  logic                        i_trigger,
  input  logic                        i_enable,
  input  logic [1:0]                  i_mode,
  input  logic [1:0]                  i_target,
  input  logic [DELAY_W-1:0]          i_delay,
  input  logic [CNT_W-1:0]            i_shot_count,
  input  logic [4:0]                  i_crresp,
  input  logic [LINE_BYTES*8-1:0]     i_line_data,
  input  logic                        i_crready,
  input  logic                        i_cdready,
  output logic                        o_crvalid,
  output logic [4:0]                  o_crresp,
  output logic                        o_cdvalid,
  output logic [C_ACE_DATA_WIDTH-1:0] o_cddata,
  output logic                        o_cdlast,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [3:0]                  o_fsm_state,
  output logic [CNT_W-1:0]            o_served_count
);

  localparam int unsigned LINE_W      = LINE_BYTES * 8;
  localparam int unsigned BEATS       = LINE_W / C_ACE_DATA_WIDTH;
  localparam int unsigned IDX_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
  localparam bit          SINGLE_BEAT = (BEATS == 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CR_DLY = 4'd1,
    S_CR     = 4'd2,
    S_CD_DLY = 4'd3,
    S_CD     = 4'd4,
    S_END    = 4'd5
  } state_t;

  state_t                     state_q, state_d;
  logic                       accept;
  logic                       enable_q;
  logic                       arm_rise;
  logic [1:0]                 mode_q;
  logic [1:0]                 target_q;
  logic [DELAY_W-1:0]         delay_q;
  logic [DELAY_W-1:0]         dcnt_q;
  logic [DELAY_W-1:0]         dly_src;
  logic                       load_dly;
  logic [4:0]                 crresp_q;
  logic [LINE_W-1:0]          line_q;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]           quota_q;
  logic [CNT_W-1:0]           served_q;
  logic [C_ACE_DATA_WIDTH-1:0] beat_arr [BEATS];

  logic                        crvalid_d, cdvalid_d, cdlast_d, busy_d, done_d;
  logic [4:0]                  crresp_d;
  logic [C_ACE_DATA_WIDTH-1:0] cddata_d;

  assign arm_rise = i_enable & ~enable_q;
  assign dly_src  = (state_q == S_IDLE) ? i_delay : delay_q;
  assign load_dly = ((state_d == S_CR_DLY) || (state_d == S_CD_DLY)) && (state_d != state_q);

  // State register
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_enable && i_trigger && (i_mode != 2'd3) &&
            ((i_mode == 2'd1) || (quota_q != '0))) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = ((i_target == 2'd0) && (i_delay != '0)) ? S_CR_DLY : S_CR;
        end
      end
      S_CR_DLY: if (dcnt_q <= DELAY_W'(1)) state_d = S_CR;
      S_CR: begin
        if (i_crready) begin
          if (!crresp_q[0]) begin
            state_d = S_END;
          end else if ((delay_q != '0) &&
                       ((target_q == 2'd1) || (target_q == 2'd3) ||
                        ((target_q == 2'd2) && SINGLE_BEAT))) begin
            state_d = S_CD_DLY;
          end else begin
            state_d = S_CD;
          end
        end
      end
      S_CD_DLY: if (dcnt_q <= DELAY_W'(1)) state_d = S_CD;
      S_CD: begin
        if (i_cdready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_END;
          end else begin
            idx_d = IDX_W'(idx_q + IDX_W'(1));
            if ((delay_q != '0) &&
                ((target_q == 2'd3) || ((target_q == 2'd2) && (idx_d == LAST_IDX))))
              state_d = S_CD_DLY;
          end
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Slice the latched line into beats, beat 0 at the LSBs
  always_comb begin
    for (int b = 0; b < int'(BEATS); b++)
      beat_arr[b] = line_q[b*C_ACE_DATA_WIDTH +: C_ACE_DATA_WIDTH];
  end

  // Output decode from the upcoming state so registered outputs track state_q
  always_comb begin
    crvalid_d = (state_d == S_CR);
    crresp_d  = '0;
    if (crvalid_d) crresp_d = (state_q == S_IDLE) ? i_crresp : crresp_q;
    cdvalid_d = (state_d == S_CD);
    cddata_d  = cdvalid_d ? beat_arr[idx_d] : '0;
    cdlast_d  = cdvalid_d && (idx_d == LAST_IDX);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_END);
  end

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      o_crvalid <= 1'b0;
      o_crresp  <= '0;
      o_cdvalid <= 1'b0;
      o_cddata  <= '0;
      o_cdlast  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_crvalid <= crvalid_d;
      o_crresp  <= crresp_d;
      o_cdvalid <= cdvalid_d;
      o_cddata  <= cddata_d;
      o_cdlast  <= cdlast_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
    end
  end

  // Latched snoop configuration, beat index and stall counter
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      mode_q   <= '0;
      target_q <= '0;
      delay_q  <= '0;
      crresp_q <= '0;
      line_q   <= '0;
      idx_q    <= '0;
      dcnt_q   <= '0;
    end else begin
      if (accept) begin
        mode_q   <= i_mode;
        target_q <= i_target;
        delay_q  <= i_delay;
        crresp_q <= i_crresp;
        line_q   <= i_line_data;
      end
      idx_q <= idx_d;
      if (load_dly)
        dcnt_q <= dly_src;
      else if (((state_q == S_CR_DLY) || (state_q == S_CD_DLY)) && (dcnt_q != '0))
        dcnt_q <= dcnt_q - DELAY_W'(1);
    end
  end

  // Arming, shot quota and served counter; a re-arm wins over an ending snoop
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      enable_q <= 1'b0;
      quota_q  <= '0;
      served_q <= '0;
    end else begin
      enable_q <= i_enable;
      if (arm_rise) begin
        served_q <= '0;
        case (i_mode)
          2'd0:    quota_q <= CNT_W'(1);
          2'd2:    quota_q <= i_shot_count;
          default: quota_q <= '0;
        endcase
      end else if (state_q == S_END) begin
        if (served_q != '1) served_q <= served_q + CNT_W'(1);
        if (((mode_q == 2'd0) || (mode_q == 2'd2)) && (quota_q != '0))
          quota_q <= quota_q - CNT_W'(1);
      end
    end
  end

  assign o_fsm_state    = state_q;
  assign o_served_count = served_q;

endmodule

// File: tb/tb_devil_snoop_injector.sv
// Directed bench for devil_snoop_injector: hand-derived state/beat sequences per scenario.
module tb_devil_snoop_injector;
  localparam int unsigned DW  = 128;
  localparam int unsigned LB  = 64;
  localparam int unsigned DLW = 32;
  localparam int unsigned CW  = 16;

  logic           ace_aclk = 1'b0;
  logic           ace_aresetn;
  logic           i_trigger, i_enable;
  logic [1:0]     i_mode, i_target;
  logic [DLW-1:0] i_delay;
  logic [CW-1:0]  i_shot_count;
  logic [4:0]     i_crresp;
  logic [LB*8-1:0] i_line_data;
  logic           i_crready, i_cdready;
  logic           o_crvalid, o_cdvalid, o_cdlast, o_busy, o_done;
  logic [4:0]     o_crresp;
  logic [DW-1:0]  o_cddata;
  logic [3:0]     o_fsm_state;
  logic [CW-1:0]  o_served_count;

  int passed = 0;
  int total  = 0;
  logic [DW-1:0] beat_v [4];
  logic [LB*8-1:0] line_v;

  always #5 ace_aclk = ~ace_aclk;

  devil_snoop_injector #(
    .C_ACE_DATA_WIDTH(DW), .LINE_BYTES(LB), .DELAY_W(DLW), .CNT_W(CW)
  ) dut (
    .ace_aclk(ace_aclk), .ace_aresetn(ace_aresetn),
    .i_trigger(i_trigger), .i_enable(i_enable), .i_mode(i_mode),
    .i_target(i_target), .i_delay(i_delay), .i_shot_count(i_shot_count),
    .i_crresp(i_crresp), .i_line_data(i_line_data),
    .i_crready(i_crready), .i_cdready(i_cdready),
    .o_crvalid(o_crvalid), .o_crresp(o_crresp),
    .o_cdvalid(o_cdvalid), .o_cddata(o_cddata), .o_cdlast(o_cdlast),
    .o_busy(o_busy), .o_done(o_done), .o_fsm_state(o_fsm_state),
    .o_served_count(o_served_count)
  );

  task automatic tick;
    @(posedge ace_aclk);
    #1;
  endtask

  task automatic test_reset;
    ace_aresetn = 1'b0;
    i_trigger = 0; i_enable = 0; i_mode = 0; i_target = 0; i_delay = '0;
    i_shot_count = '0; i_crresp = '0; i_line_data = line_v;
    i_crready = 1; i_cdready = 1;
    repeat (2) @(posedge ace_aclk);
    #1;
    total++;
    if ({o_crvalid, o_cdvalid, o_cdlast, o_busy, o_done, o_crresp, o_fsm_state} !== '0 ||
        o_cddata !== '0 || o_served_count !== '0)
      $display("FAIL reset_outputs: got st=%0d crv=%b cdv=%b busy=%b cnt=%0d, want all 0",
               o_fsm_state, o_crvalid, o_cdvalid, o_busy, o_served_count);
    else passed++;
    ace_aresetn = 1'b1;
    tick;
    total++;
    if (o_fsm_state !== 4'd0) $display("FAIL reset_idle: got %0d want 0", o_fsm_state);
    else passed++;
  endtask

  // One-shot, last-beat stall of 1 cycle, ready tied high
  task automatic test_one_shot;
    int exp_st [8];
    int beat;
    exp_st = '{2, 4, 4, 4, 3, 4, 5, 0};
    beat = 0;
    i_mode = 2'd0; i_target = 2'd2; i_delay = 32'd1; i_crresp = 5'b00001;
    i_enable = 1; tick;
    i_trigger = 1;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (c == 0) i_trigger = 0;
      total++;
      if (o_fsm_state !== 4'(exp_st[c]) ||
          {o_crvalid, o_cdvalid, o_done} !== {exp_st[c] == 2, exp_st[c] == 4, exp_st[c] == 5})
        $display("FAIL one_shot_seq[%0d]: got st=%0d crv=%b cdv=%b done=%b want st=%0d",
                 c, o_fsm_state, o_crvalid, o_cdvalid, o_done, exp_st[c]);
      else passed++;
      if (exp_st[c] == 2) begin
        total++;
        if (o_crresp !== 5'b00001 || o_busy !== 1'b1)
          $display("FAIL one_shot_cr: got resp=%b busy=%b want 00001/1", o_crresp, o_busy);
        else passed++;
      end
      if (exp_st[c] == 4) begin
        total++;
        if (o_cddata !== beat_v[beat] || o_cdlast !== (beat == 3))
          $display("FAIL one_shot_beat%0d: got %h last=%b want %h last=%b",
                   beat, o_cddata, o_cdlast, beat_v[beat], beat == 3);
        else passed++;
        beat++;
      end
    end
    total++;
    if (o_served_count !== 16'd1 || o_busy !== 1'b0)
      $display("FAIL one_shot_count: got %0d busy=%b want 1/0", o_served_count, o_busy);
    else passed++;
    i_trigger = 1;
    for (int c = 0; c < 3; c++) begin
      tick;
      total++;
      if (o_fsm_state !== 4'd0 || o_busy !== 1'b0)
        $display("FAIL one_shot_ignore: got st=%0d busy=%b want 0/0", o_fsm_state, o_busy);
      else passed++;
    end
    i_trigger = 0;
  endtask

  // Continuous mode, CR stall of 2, DataTransfer=0 so no CD phase
  task automatic test_continuous;
    int exp_st [5];
    int dones;
    exp_st = '{1, 1, 2, 5, 0};
    dones = 0;
    i_enable = 0; tick;
    i_mode = 2'd1; i_target = 2'd0; i_delay = 32'd2; i_crresp = 5'b00000;
    i_enable = 1; tick;
    total++;
    if (o_served_count !== 16'd0) $display("FAIL cont_clear: got %0d want 0", o_served_count);
    else passed++;
    i_trigger = 1;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 5; c++) begin
        if (k == 4 && c == 4) i_trigger = 0;
        tick;
        if (o_done === 1'b1) dones++;
        total++;
        if (o_fsm_state !== 4'(exp_st[c]) || o_cdvalid !== 1'b0 ||
            o_crvalid !== (exp_st[c] == 2) || (o_crvalid && o_crresp !== 5'd0))
          $display("FAIL cont_seq[%0d.%0d]: got st=%0d crv=%b cdv=%b want st=%0d",
                   k, c, o_fsm_state, o_crvalid, o_cdvalid, exp_st[c]);
        else passed++;
      end
    end
    total++;
    if (dones !== 5 || o_served_count !== 16'd5)
      $display("FAIL cont_count: got done=%0d cnt=%0d want 5/5", dones, o_served_count);
    else passed++;
  endtask

  // N-shot quota of 3, first-beat stall of 4, then re-arm
  task automatic test_n_shot;
    int exp_st [11];
    exp_st = '{2, 3, 3, 3, 3, 4, 4, 4, 4, 5, 0};
    i_enable = 0; tick;
    i_mode = 2'd2; i_shot_count = 16'd3; i_target = 2'd1; i_delay = 32'd4; i_crresp = 5'b00001;
    i_enable = 1; tick;
    for (int k = 0; k < 3; k++) begin
      i_trigger = 1;
      for (int c = 0; c < 11; c++) begin
        tick;
        if (c == 0) i_trigger = 0;
        total++;
        if (o_fsm_state !== 4'(exp_st[c]) || o_cdvalid !== (exp_st[c] == 4))
          $display("FAIL nshot_seq[%0d.%0d]: got st=%0d cdv=%b want st=%0d",
                   k, c, o_fsm_state, o_cdvalid, exp_st[c]);
        else passed++;
      end
      total++;
      if (o_served_count !== 16'(k + 1))
        $display("FAIL nshot_count[%0d]: got %0d want %0d", k, o_served_count, k + 1);
      else passed++;
    end
    i_trigger = 1;
    repeat (3) tick;
    total++;
    if (o_fsm_state !== 4'd0 || o_busy !== 1'b0 || o_served_count !== 16'd3)
      $display("FAIL nshot_exhausted: got st=%0d busy=%b cnt=%0d want 0/0/3",
               o_fsm_state, o_busy, o_served_count);
    else passed++;
    i_trigger = 0;
    i_enable = 0; tick;
    i_enable = 1; tick;
    total++;
    if (o_served_count !== 16'd0) $display("FAIL nshot_rearm: got %0d want 0", o_served_count);
    else passed++;
  endtask

  // Every-beat stall of 3, CD back-pressure on beat 1, config changed mid-snoop
  task automatic test_every_beat;
    int exp_st [21];
    int exp_ix [21];
    int stall;
    exp_st = '{2, 3, 3, 3, 4, 3, 3, 3, 4, 4, 4, 3, 3, 3, 4, 3, 3, 3, 4, 5, 0};
    exp_ix = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 2, 0, 0, 0, 3, 0, 0};
    stall = 0;
    i_mode = 2'd1; i_target = 2'd3; i_delay = 32'd3; i_crresp = 5'b00001; i_cdready = 1;
    i_trigger = 1;
    for (int c = 0; c < 21; c++) begin
      tick;
      if (c == 0) begin
        i_trigger = 0;
        i_line_data = '1; i_target = 2'd0; i_delay = '0; i_crresp = 5'b00000;
      end
      total++;
      if (o_fsm_state !== 4'(exp_st[c]) || o_cdvalid !== (exp_st[c] == 4) ||
          (exp_st[c] == 4 && (o_cddata !== beat_v[exp_ix[c]] || o_cdlast !== (exp_ix[c] == 3))))
        $display("FAIL every_seq[%0d]: got st=%0d cdv=%b data=%h want st=%0d data=%h",
                 c, o_fsm_state, o_cdvalid, o_cddata, exp_st[c], beat_v[exp_ix[c]]);
      else passed++;
      if (exp_st[c] == 4 && exp_ix[c] == 1 && stall < 2) begin
        i_cdready = 0;
        stall++;
      end else begin
        i_cdready = 1;
      end
    end
    i_line_data = line_v;
  endtask

  // Async reset while beat 2 is on the bus
  task automatic test_reset_mid;
    i_mode = 2'd1; i_target = 2'd1; i_delay = '0; i_crresp = 5'b00001;
    i_trigger = 1;
    tick; i_trigger = 0;
    repeat (3) tick;
    total++;
    if (o_fsm_state !== 4'd4 || o_cddata !== beat_v[2])
      $display("FAIL rst_mid_pre: got st=%0d data=%h want 4/%h", o_fsm_state, o_cddata, beat_v[2]);
    else passed++;
    #1 ace_aresetn = 1'b0;
    #1;
    total++;
    if ({o_crvalid, o_cdvalid, o_cdlast, o_busy, o_done, o_crresp, o_fsm_state} !== '0 ||
        o_cddata !== '0 || o_served_count !== '0)
      $display("FAIL rst_mid_zero: got st=%0d cdv=%b busy=%b cnt=%0d want all 0",
               o_fsm_state, o_cdvalid, o_busy, o_served_count);
    else passed++;
    @(negedge ace_aclk);
    ace_aresetn = 1'b1;
    tick;
    total++;
    if (o_fsm_state !== 4'd0 || o_served_count !== 16'd0 || o_busy !== 1'b0)
      $display("FAIL rst_mid_after: got st=%0d cnt=%0d busy=%b want 0/0/0",
               o_fsm_state, o_served_count, o_busy);
    else passed++;
  endtask

  // Enable dropped during the CR stall: snoop completes, no new accept
  task automatic test_enable_drop;
    int exp_st [11];
    exp_st = '{1, 1, 2, 4, 4, 4, 4, 5, 0, 0, 0};
    i_mode = 2'd1; i_target = 2'd0; i_delay = 32'd2; i_crresp = 5'b00001;
    i_crready = 1; i_cdready = 1;
    i_trigger = 1;
    for (int c = 0; c < 11; c++) begin
      tick;
      if (c == 0) i_enable = 0;
      total++;
      if (o_fsm_state !== 4'(exp_st[c]) || o_crvalid !== (exp_st[c] == 2) ||
          o_cdvalid !== (exp_st[c] == 4) || o_busy !== (exp_st[c] != 0))
        $display("FAIL en_drop_seq[%0d]: got st=%0d busy=%b want st=%0d",
                 c, o_fsm_state, o_busy, exp_st[c]);
      else passed++;
    end
    i_trigger = 0;
  endtask

  initial begin
    beat_v[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    beat_v[1] = 128'h11111111_22222222_33333333_44444444;
    beat_v[2] = 128'hdeadbeef_cafef00d_0badc0de_feedface;
    beat_v[3] = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
    line_v = {beat_v[3], beat_v[2], beat_v[1], beat_v[0]};
    test_reset;
    test_one_shot;
    test_continuous;
    test_n_shot;
    test_every_beat;
    test_reset_mid;
    test_enable_drop;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
